core_mem_arbiter: RTL

- Shares one single-ported data/instruction memory among NUM_CORES cores.
- Each core issues one-cycle read pulses (fetch in F0, LD/LDR in E0) and one-cycle store pulses (ST in E0), and cannot stall on stores.
- The arbiter captures every pulse into per-core pending slots and serves them round-robin over a req/ack memory handshake.
- Read data goes back to the requesting core with a one-cycle ready pulse.

---
 rtl/core_mem_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//
// Shares one single-ported memory among NUM_CORES cores. Every one-cycle read
// or store pulse from a core is captured into that core's pending read slot
// or pending write slot. Pending work is served round-robin, one transaction
// at a time, over a req/ack handshake. Read data goes back to the requesting
// core together with a one-cycle ready pulse.
//
// Ports:
//   clk, rst         system clock (rising edge), asynchronous active-high reset
//   core_rd_req      per-core read pulse
//   core_rd_addr     per-core read address, core i at [i*ADDR_W +: ADDR_W]
//   core_rd_ready    one-cycle read-complete pulse, at most one bit set
//   core_rd_data     read data, held until the next read completion
//   core_wr_req      per-core store pulse
//   core_wr_addr     per-core store address
//   core_wr_data     per-core store data
//   mem_req          memory request, held until mem_ack
//   mem_we           1 = write, 0 = read
//   mem_addr         memory address
//   mem_wdata        memory write data
//   mem_ack          memory completion (read data valid in the same cycle)
//   mem_rdata        memory read data
//   wr_overflow      sticky per-core flag: a store was dropped because the
//                    write slot was still full

module core_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_rd_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_rd_addr,
    output logic [NUM_CORES-1:0]        core_rd_ready,
    output logic [DATA_W-1:0]           core_rd_data,
    input  logic [NUM_CORES-1:0]        core_wr_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_wr_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wr_data,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [NUM_CORES-1:0]        wr_overflow
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    // One extra bit so rr_ptr + offset can exceed NUM_CORES before wrapping.
    localparam logic [PTR_W:0] NC = (PTR_W + 1)'(NUM_CORES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   rd_pend_q, rd_pend_d;
    logic [NUM_CORES-1:0]   wr_pend_q, wr_pend_d;
    logic [NUM_CORES-1:0]   wr_overflow_q, wr_overflow_d;
    logic [NUM_CORES-1:0]   core_rd_ready_q, core_rd_ready_d;
    logic [ADDR_W-1:0]      rd_addr_q [NUM_CORES];
    logic [ADDR_W-1:0]      rd_addr_d [NUM_CORES];
    logic [ADDR_W-1:0]      wr_addr_q [NUM_CORES];
    logic [ADDR_W-1:0]      wr_addr_d [NUM_CORES];
    logic [DATA_W-1:0]      wr_data_q [NUM_CORES];
    logic [DATA_W-1:0]      wr_data_d [NUM_CORES];
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_q, grant_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]      core_rd_data_q, core_rd_data_d;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   wr_retire;
    logic [PTR_W:0]         idx;
    logic [PTR_W-1:0]       gnt;
    logic                   found;

    // Next-state logic. Retirement is applied before capture so that a pulse
    // landing in the same cycle its slot retires leaves the slot pending.
    // Grants only look at registered slots, so a pulse is never granted in
    // the cycle it is captured.
    always_comb begin
        state_d         = state_q;
        rd_pend_d       = rd_pend_q;
        wr_pend_d       = wr_pend_q;
        wr_overflow_d   = wr_overflow_q;
        core_rd_ready_d = '0;
        rd_addr_d       = rd_addr_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        core_rd_data_d  = core_rd_data_q;
        eligible        = rd_pend_q | wr_pend_q;
        wr_retire       = '0;
        idx             = '0;
        gnt             = '0;
        found           = 1'b0;

        case (state_q)
            IDLE: begin
                for (int off = 0; off < NUM_CORES; off++) begin
                    idx = {1'b0, rr_ptr_q} + (PTR_W + 1)'(off);
                    if (idx >= NC) begin
                        idx = idx - NC;
                    end
                    if (!found && eligible[idx[PTR_W-1:0]]) begin
                        found = 1'b1;
                        gnt   = idx[PTR_W-1:0];
                    end
                end
                if (found) begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    grant_d   = gnt;
                    if ({1'b0, gnt} == NC - 1'b1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt + 1'b1;
                    end
                    // A pending store goes ahead of the same core's read.
                    if (wr_pend_q[gnt]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_addr_q[gnt];
                        mem_wdata_d = wr_data_q[gnt];
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = rd_addr_q[gnt];
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        wr_pend_d[grant_q] = 1'b0;
                        wr_retire[grant_q] = 1'b1;
                    end else begin
                        rd_pend_d[grant_q]       = 1'b0;
                        core_rd_data_d           = mem_rdata;
                        core_rd_ready_d[grant_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_rd_req[i]) begin
                rd_pend_d[i] = 1'b1;
                rd_addr_d[i] = core_rd_addr[i*ADDR_W +: ADDR_W];
            end
            if (core_wr_req[i]) begin
                // Cores cannot stall on stores, so a store into a still-full
                // slot is lost; the sticky flag records that it happened.
                if (wr_pend_q[i] && !wr_retire[i]) begin
                    wr_overflow_d[i] = 1'b1;
                end else begin
                    wr_pend_d[i] = 1'b1;
                    wr_addr_d[i] = core_wr_addr[i*ADDR_W +: ADDR_W];
                    wr_data_d[i] = core_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // State register. Reset discards all pending work and drops mem_req
    // immediately, even in the middle of a transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rd_pend_q       <= '0;
            wr_pend_q       <= '0;
            wr_overflow_q   <= '0;
            core_rd_ready_q <= '0;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            core_rd_data_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                rd_addr_q[i] <= '0;
                wr_addr_q[i] <= '0;
                wr_data_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            rd_pend_q       <= rd_pend_d;
            wr_pend_q       <= wr_pend_d;
            wr_overflow_q   <= wr_overflow_d;
            core_rd_ready_q <= core_rd_ready_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            core_rd_data_q  <= core_rd_data_d;
            rd_addr_q       <= rd_addr_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign core_rd_ready = core_rd_ready_q;
    assign core_rd_data  = core_rd_data_q;
    assign wr_overflow   = wr_overflow_q;

endmodule
